// File: rtl/rpn_evaluator_if.sv
// Token and result handshake bundle for the RPN evaluator.
// Upstream tokens use a four-phase stb/ack pair; results use stb/ack toward downstream.
interface rpn_evaluator_if #(
  parameter int WIDTH = 32
);
  logic             input_stb;
  logic [WIDTH-1:0] input_data;
  logic             is_input_operator;
  logic             input_ack;
  logic             result_stb;
  logic [WIDTH-1:0] result_data;
  logic             result_error;
  logic             result_ack;

  // Token source / result sink side (testbench or upstream logic).
  modport master (
    output input_stb, input_data, is_input_operator, result_ack,
    input  input_ack, result_stb, result_data, result_error
  );

  // Evaluator side.
  modport slave (
    input  input_stb, input_data, is_input_operator, result_ack,
    output input_ack, result_stb, result_data, result_error
  );
endinterface

// File: rtl/rpn_evaluator.sv
// Reverse-Polish expression evaluator with an internal operand stack.
// One token is handled per four-phase handshake; '=' emits the single remaining
// stack value, or flags an error if the expression was malformed.
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic          CLK,
  input logic          RST,
  rpn_evaluator_if.slave bus
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESULT, ACK} state_t;

  state_t                  state_q, state_d;
  logic [SP_W-1:0]         sp_q, sp_d;
  logic                    err_q, err_d;
  logic signed [WIDTH-1:0] tok_data_q, tok_data_d;
  logic                    tok_op_q, tok_op_d;
  logic                    input_ack_q, input_ack_d;
  logic                    result_stb_q, result_stb_d;
  logic signed [WIDTH-1:0] result_data_q, result_data_d;
  logic                    result_error_q, result_error_d;

  logic signed [WIDTH-1:0] stack_q [DEPTH];

  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic signed [WIDTH-1:0] wr_data;

  logic [IDX_W-1:0]        top_idx, next_idx;
  logic signed [WIDTH-1:0] top_b, next_a;

  // Two's-complement wrap-around arithmetic; the product keeps only its low WIDTH bits.
  function automatic logic signed [WIDTH-1:0] alu(input logic [2:0] op,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    case (op)
      OP_MUL:  r = a * b;
      OP_ADD:  r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign next_idx = IDX_W'(sp_q - SP_W'(2));
  assign top_b    = stack_q[top_idx];
  assign next_a   = stack_q[next_idx];

  assign bus.input_ack    = input_ack_q;
  assign bus.result_stb   = result_stb_q;
  assign bus.result_data  = result_data_q;
  assign bus.result_error = result_error_q;

  // Control state and handshake registers; reset aborts any token or pending result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      sp_q           <= '0;
      err_q          <= 1'b0;
      input_ack_q    <= 1'b0;
      result_stb_q   <= 1'b0;
      result_data_q  <= '0;
      result_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      err_q          <= err_d;
      input_ack_q    <= input_ack_d;
      result_stb_q   <= result_stb_d;
      result_data_q  <= result_data_d;
      result_error_q <= result_error_d;
    end
  end

  // Captured token and operand stack are pure data, qualified by state and sp.
  always_ff @(posedge CLK) begin
    tok_data_q <= tok_data_d;
    tok_op_q   <= tok_op_d;
    if (wr_en) stack_q[wr_idx] <= wr_data;
  end

  // Next-state logic: capture, execute one token, present result, then finish the token handshake.
  always_comb begin
    state_d        = state_q;
    sp_d           = sp_q;
    err_d          = err_q;
    tok_data_d     = tok_data_q;
    tok_op_d       = tok_op_q;
    input_ack_d    = input_ack_q;
    result_stb_d   = result_stb_q;
    result_data_d  = result_data_q;
    result_error_d = result_error_q;
    wr_en          = 1'b0;
    wr_idx         = IDX_W'(sp_q);
    wr_data        = tok_data_q;

    case (state_q)
      IDLE: begin
        if (bus.input_stb) begin
          tok_data_d = bus.input_data;
          tok_op_d   = bus.is_input_operator;
          state_d    = EXEC;
        end
      end

      EXEC: begin
        state_d = ACK;
        if (!tok_op_q) begin
          // Once the expression is known bad, numbers are swallowed without touching the stack.
          if (!err_q) begin
            if (sp_q < SP_W'(DEPTH)) begin
              wr_en  = 1'b1;
              wr_idx = IDX_W'(sp_q);
              sp_d   = sp_q + SP_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          case (tok_data_q[2:0])
            OP_MUL, OP_ADD, OP_SUB: begin
              if (!err_q) begin
                if (sp_q >= SP_W'(2)) begin
                  wr_en   = 1'b1;
                  wr_idx  = next_idx;
                  wr_data = alu(tok_data_q[2:0], next_a, top_b);
                  sp_d    = sp_q - SP_W'(1);
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            OP_EQ: begin
              state_d = RESULT;
              if (sp_q == SP_W'(1) && !err_q) begin
                result_data_d  = top_b;
                result_error_d = 1'b0;
              end else begin
                result_data_d  = '0;
                result_error_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      RESULT: begin
        // Raise stb one edge after entry; only an ack seen while stb is up retires the result.
        if (!result_stb_q) begin
          result_stb_d = 1'b1;
        end else if (bus.result_ack) begin
          result_stb_d = 1'b0;
          sp_d         = '0;
          err_d        = 1'b0;
          state_d      = ACK;
        end
      end

      ACK: begin
        if (bus.input_stb) begin
          input_ack_d = 1'b1;
        end else begin
          input_ack_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Self-checking bench for rpn_evaluator: scoreboarded expressions plus timing and reset scenarios.
module tb_rpn_evaluator;

  localparam int W = 32;
  localparam logic [31:0] C_MUL = 32'd1;
  localparam logic [31:0] C_ADD = 32'd2;
  localparam logic [31:0] C_SUB = 32'd3;
  localparam logic [31:0] C_EQ  = 32'd4;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  exp_t sb[$];

  rpn_evaluator_if #(.WIDTH(W)) bus ();

  rpn_evaluator #(.WIDTH(W), .DEPTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Drive one non-'=' token through the full four-phase handshake.
  task automatic send_tok(input logic [31:0] d, input logic op);
    int n;
    @(negedge CLK);
    bus.input_stb = 1'b1;
    bus.input_data = d;
    bus.is_input_operator = op;
    n = 0;
    while (bus.input_ack !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (bus.input_ack !== 1'b1) begin
      errors++;
      $display("FAIL tok_ack_timeout got %b required 1", bus.input_ack);
    end
    bus.input_stb = 1'b0;
    n = 0;
    while (bus.input_ack !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
    if (bus.input_ack !== 1'b0) begin
      errors++;
      $display("FAIL tok_ack_release_timeout got %b required 0", bus.input_ack);
    end
  endtask

  // Drive '=', capture the result, acknowledge it, then finish the token handshake.
  task automatic eval_eq(output logic [31:0] d, output logic e);
    int n;
    @(negedge CLK);
    bus.input_stb = 1'b1;
    bus.input_data = C_EQ;
    bus.is_input_operator = 1'b1;
    n = 0;
    while (bus.result_stb !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (bus.result_stb !== 1'b1) begin
      errors++;
      $display("FAIL result_stb_timeout got %b required 1", bus.result_stb);
    end
    d = bus.result_data;
    e = bus.result_error;
    bus.result_ack = 1'b1;
    @(negedge CLK);
    bus.result_ack = 1'b0;
    n = 0;
    while (bus.input_ack !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (bus.input_ack !== 1'b1) begin
      errors++;
      $display("FAIL eq_ack_timeout got %b required 1", bus.input_ack);
    end
    bus.input_stb = 1'b0;
    n = 0;
    while (bus.input_ack !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b0) begin errors++; $display("FAIL rst_input_ack got %b required 0", bus.input_ack); end
    checks++; if (bus.result_stb !== 1'b0) begin errors++; $display("FAIL rst_result_stb got %b required 0", bus.result_stb); end
    checks++; if (bus.result_data !== 32'd0) begin errors++; $display("FAIL rst_result_data got %h required 0", bus.result_data); end
    checks++; if (bus.result_error !== 1'b0) begin errors++; $display("FAIL rst_result_error got %b required 0", bus.result_error); end
    checks++; if (dut.sp_q !== '0) begin errors++; $display("FAIL rst_sp got %0d required 0", dut.sp_q); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    exp_t x; logic [31:0] d; logic e;
    send_tok(32'd3, 1'b0); send_tok(32'd4, 1'b0); send_tok(C_ADD, 1'b1);
    send_tok(32'd2, 1'b0); send_tok(C_MUL, 1'b1);
    sb.push_back('{d: 32'd14, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL basic_expr got %h/%b required %h/%b", d, e, x.d, x.e); end
    checks++; if (dut.sp_q !== '0) begin errors++; $display("FAIL basic_sp_after got %0d required 0", dut.sp_q); end
  endtask

  task automatic test_sub_wrap();
    exp_t x; logic [31:0] d; logic e;
    send_tok(32'd5, 1'b0); send_tok(32'd9, 1'b0); send_tok(C_SUB, 1'b1);
    sb.push_back('{d: 32'hFFFF_FFFC, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL sub_wrap got %h/%b required %h/%b", d, e, x.d, x.e); end
    send_tok(32'h0001_0000, 1'b0); send_tok(32'h0001_0003, 1'b0); send_tok(C_MUL, 1'b1);
    sb.push_back('{d: 32'h0003_0000, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL mul_wrap got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_underflow();
    exp_t x; logic [31:0] d; logic e;
    send_tok(32'd7, 1'b0); send_tok(C_ADD, 1'b1);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL underflow_op got %h/%b required %h/%b", d, e, x.d, x.e); end
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL lone_eq got %h/%b required %h/%b", d, e, x.d, x.e); end
    send_tok(32'd2, 1'b0); send_tok(32'd2, 1'b0); send_tok(C_MUL, 1'b1);
    sb.push_back('{d: 32'd4, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL recover_after_err got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_sticky_and_invalid();
    exp_t x; logic [31:0] d; logic e;
    // Error from underflow must survive a later push that would make sp=1.
    send_tok(C_SUB, 1'b1); send_tok(32'd3, 1'b0);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL sticky_err got %h/%b required %h/%b", d, e, x.d, x.e); end
    send_tok(32'd5, 1'b0); send_tok(32'd7, 1'b1);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL invalid_op7 got %h/%b required %h/%b", d, e, x.d, x.e); end
    send_tok(32'd8, 1'b0); send_tok(32'd0, 1'b1);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL invalid_op0 got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_stack_depth();
    exp_t x; logic [31:0] d; logic e;
    for (int i = 0; i < 16; i++) send_tok(32'd1, 1'b0);
    checks++; if (dut.sp_q !== 5'd16) begin errors++; $display("FAIL full_sp got %0d required 16", dut.sp_q); end
    for (int i = 0; i < 15; i++) send_tok(C_ADD, 1'b1);
    sb.push_back('{d: 32'd16, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL full_sum got %h/%b required %h/%b", d, e, x.d, x.e); end
    for (int i = 0; i < 17; i++) send_tok(32'(i), 1'b0);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL overflow got %h/%b required %h/%b", d, e, x.d, x.e); end
    send_tok(32'd1, 1'b0); send_tok(32'd2, 1'b0);
    sb.push_back('{d: 32'd0, e: 1'b1});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL eq_sp2 got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_latency();
    exp_t x; logic [31:0] d; logic e; int n;
    @(negedge CLK);
    bus.input_stb = 1'b1; bus.input_data = 32'd9; bus.is_input_operator = 1'b0;
    @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b0) begin errors++; $display("FAIL lat_T0 got %b required 0", bus.input_ack); end
    @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b0) begin errors++; $display("FAIL lat_T1 got %b required 0", bus.input_ack); end
    @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b1) begin errors++; $display("FAIL lat_T2 got %b required 1", bus.input_ack); end
    // Holding stb keeps ack high and must not consume the token again.
    repeat (3) @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b1 || dut.sp_q !== 5'd1) begin errors++; $display("FAIL lat_hold got ack %b sp %0d required 1 1", bus.input_ack, dut.sp_q); end
    bus.input_stb = 1'b0;
    n = 0;
    while (bus.input_ack !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
    checks++; if (bus.input_ack !== 1'b0) begin errors++; $display("FAIL lat_release got %b required 0", bus.input_ack); end
    sb.push_back('{d: 32'd9, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL lat_result got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_ack_hold();
    exp_t x; int n; logic ok;
    send_tok(32'd20, 1'b0); send_tok(32'd22, 1'b0); send_tok(C_ADD, 1'b1);
    sb.push_back('{d: 32'd42, e: 1'b0});
    x = sb.pop_front();
    @(negedge CLK);
    bus.input_stb = 1'b1; bus.input_data = C_EQ; bus.is_input_operator = 1'b1;
    n = 0;
    while (bus.result_stb !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.result_stb !== 1'b1 || bus.result_data !== x.d || bus.result_error !== x.e || bus.input_ack !== 1'b0) ok = 1'b0;
      @(negedge CLK);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_stable got stb %b data %h err %b ack %b required 1 %h %b 0", bus.result_stb, bus.result_data, bus.result_error, bus.input_ack, x.d, x.e); end
    bus.result_ack = 1'b1;
    @(negedge CLK);
    bus.result_ack = 1'b0;
    checks++; if (bus.result_stb !== 1'b0 || bus.input_ack !== 1'b0) begin errors++; $display("FAIL hold_after_rack got stb %b ack %b required 0 0", bus.result_stb, bus.input_ack); end
    @(negedge CLK);
    checks++; if (bus.input_ack !== 1'b1) begin errors++; $display("FAIL hold_ack_rise got %b required 1", bus.input_ack); end
    bus.input_stb = 1'b0;
    n = 0;
    while (bus.input_ack !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
  endtask

  task automatic test_reset_in_result();
    exp_t x; logic [31:0] d; logic e; int n;
    send_tok(32'd1, 1'b0); send_tok(32'd2, 1'b0); send_tok(C_ADD, 1'b1);
    @(negedge CLK);
    bus.input_stb = 1'b1; bus.input_data = C_EQ; bus.is_input_operator = 1'b1;
    n = 0;
    while (bus.result_stb !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    checks++; if (bus.result_stb !== 1'b1 || bus.result_data !== 32'd3) begin errors++; $display("FAIL pre_rst_result got %b/%h required 1/3", bus.result_stb, bus.result_data); end
    RST = 1'b1;
    bus.input_stb = 1'b0;
    @(negedge CLK);
    checks++; if (bus.result_stb !== 1'b0 || dut.sp_q !== '0 || bus.input_ack !== 1'b0 || bus.result_data !== 32'd0) begin
      errors++; $display("FAIL rst_in_result got stb %b sp %0d ack %b data %h required 0 0 0 0", bus.result_stb, dut.sp_q, bus.input_ack, bus.result_data);
    end
    RST = 1'b0;
    send_tok(32'd6, 1'b0);
    sb.push_back('{d: 32'd6, e: 1'b0});
    eval_eq(d, e); x = sb.pop_front();
    checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL post_rst_expr got %h/%b required %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_back_to_back();
    exp_t x; logic [31:0] d; logic e; logic [31:0] a, b, r, c;
    int k;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; k = $urandom_range(0, 2);
      case (k)
        0: begin c = C_MUL; r = a * b; end
        1: begin c = C_ADD; r = a + b; end
        default: begin c = C_SUB; r = a - b; end
      endcase
      send_tok(a, 1'b0); send_tok(b, 1'b0); send_tok(c, 1'b1);
      sb.push_back('{d: r, e: 1'b0});
      eval_eq(d, e); x = sb.pop_front();
      checks++; if (d !== x.d || e !== x.e) begin errors++; $display("FAIL b2b_%0d op %0d got %h/%b required %h/%b", i, k, d, e, x.d, x.e); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.input_stb = 1'b0;
    bus.input_data = '0;
    bus.is_input_operator = 1'b0;
    bus.result_ack = 1'b0;
    test_reset();
    test_basic();
    test_sub_wrap();
    test_underflow();
    test_sticky_and_invalid();
    test_stack_depth();
    test_latency();
    test_ack_hold();
    test_reset_in_result();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
